// File: rtl/booth_mult_pkg.sv
// Shared types and helpers for the radix-2 Booth multiplier.
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        NOP,
        ADD,
        SUB
    } booth_op_t;

    // Step counter must hold 0..DW.
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 2);
    endfunction

endpackage

// File: rtl/booth_multiplier_if.sv
// Start/ready/done handshake and operand/product bus of the Booth multiplier.
interface booth_multiplier_if #(
    parameter int DW = 8
);
    logic              start;
    logic              signed_mode;
    logic [DW-1:0]     multiplicand;
    logic [DW-1:0]     multiplier;
    logic              ready;
    logic              busy;
    logic              done;
    logic [2*DW-1:0]   product;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output ready, busy, done, product
    );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of Mx, then an
// arithmetic right shift of {A, Q, q-1}.
module booth_step
    import booth_mult_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW+1:0] acc,
    input  logic [DW:0]   q,
    input  logic          q_m1,
    input  logic [DW+1:0] mx,
    output logic [DW+1:0] acc_next,
    output logic [DW:0]   q_next,
    output logic          q_m1_next
);

    booth_op_t       op;
    logic [DW+1:0]   sum;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        op  = NOP;
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase
        case (op)
            ADD:     sum = acc + mx;
            SUB:     sum = acc - mx;
            default: sum = acc;
        endcase
        // The dropped LSB of Q becomes the new q-1; A's sign bit is replicated.
        {acc_next, q_next, q_m1_next} = {sum[DW+1], sum, q};
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: IDLE/RUN/DONE FSM, step counter and
// operand/accumulator registers around a combinational booth_step.
module booth_multiplier
    import booth_mult_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst,
    booth_multiplier_if.slave  bus
);

    localparam int            CW        = cnt_width(DW);
    localparam logic [CW-1:0] LAST_STEP = CW'(DW);

    state_t          state;
    state_t          state_next;
    logic            ready;
    logic            accept;

    logic [DW+1:0]   acc;
    logic [DW+1:0]   acc_n;
    logic [DW+1:0]   mx;
    logic [DW:0]     q;
    logic [DW:0]     q_n;
    logic            q_m1;
    logic            q_m1_n;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] product;
    logic            ext_m;
    logic            ext_q;

    booth_step #(.DW(DW)) u_step (
        .acc       (acc),
        .q         (q),
        .q_m1      (q_m1),
        .mx        (mx),
        .acc_next  (acc_n),
        .q_next    (q_n),
        .q_m1_next (q_m1_n)
    );

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: ready = 1'b1;
            RUN:  if (cnt == LAST_STEP) state_next = DONE;
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        accept = ready & bus.start;
        if (accept) state_next = RUN;
    end

    // Extension bit is the operand's sign only in signed mode.
    assign ext_m = bus.signed_mode & bus.multiplicand[DW-1];
    assign ext_q = bus.signed_mode & bus.multiplier[DW-1];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            mx      <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                acc  <= '0;
                mx   <= {{2{ext_m}}, bus.multiplicand};
                q    <= {ext_q, bus.multiplier};
                q_m1 <= 1'b0;
                cnt  <= '0;
            end else if (state == RUN) begin
                acc  <= acc_n;
                q    <= q_n;
                q_m1 <= q_m1_n;
                cnt  <= cnt + CW'(1);
                if (cnt == LAST_STEP) product <= {acc_n[DW-2:0], q_n};
            end
        end
    end

    assign bus.ready   = ready;
    assign bus.busy    = ~ready;
    assign bus.done    = (state == DONE);
    assign bus.product = product;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier (DW=8) against an integer-arithmetic
// product model.
module tb_booth_multiplier;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    booth_multiplier_if #(.DW(DW)) bus ();

    booth_multiplier #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [7:0] m, input logic [7:0] q, input logic sm);
        int a;
        int b;
        a = (sm && m[7]) ? int'(m) - 256 : int'(m);
        b = (sm && q[7]) ? int'(q) - 256 : int'(q);
        return 16'(a * b);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and follows it to done; poke >= 0 pulses start with
    // different operands on that RUN edge, which must be ignored.
    task automatic run_op(input logic [7:0] m, input logic [7:0] q, input logic sm,
                          input string tag, input int poke);
        logic [15:0] exp;
        int          edges;
        bit          seen;
        bit          busy_ok;
        exp = model(m, q, sm);
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.signed_mode  = sm;
        bus.start        = 1'b1;
        step();
        edges   = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && edges < 40) begin
            bus.start = (edges == poke);
            if (edges == poke) begin
                bus.multiplicand = 8'h01;
                bus.multiplier   = 8'h01;
            end else begin
                bus.multiplicand = 8'($urandom);
                bus.multiplier   = 8'($urandom);
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            step();
            edges++;
            seen = bus.done;
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(edges), 32'd9);
        check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
        check({tag, "_product"}, 32'(bus.product), 32'(exp));
        check({tag, "_ready_done"}, 32'(bus.ready), 32'd1);
        step();
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_product_hold"}, 32'(bus.product), 32'(exp));
    endtask

    initial begin
        int          pulses[$];
        int          cnt_done;
        bit          stable;
        logic [7:0]  rm;
        logic [7:0]  rq;
        logic        rs;

        bus.start        = 1'b1;
        bus.signed_mode  = 1'b0;
        bus.multiplicand = 8'h55;
        bus.multiplier   = 8'h7F;
        rst              = 1'b1;
        repeat (3) step();
        check("rst_product", 32'(bus.product), 32'h0000);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        rst       = 1'b0;
        step();

        run_op(8'h55, 8'h7F, 1'b0, "u_55x7f", -1);
        run_op(8'hFF, 8'hFF, 1'b0, "u_ffxff", -1);
        run_op(8'h80, 8'h80, 1'b1, "s_80x80", -1);
        run_op(8'hFF, 8'h02, 1'b1, "s_ffx02", -1);
        run_op(8'hFF, 8'h02, 1'b0, "u_ffx02", -1);
        run_op(8'h55, 8'h55, 1'b0, "ignore_start", 3);

        // Back-to-back with start held high.
        bus.multiplicand = 8'h55;
        bus.multiplier   = 8'h7F;
        bus.signed_mode  = 1'b0;
        bus.start        = 1'b1;
        step();
        stable = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (bus.done === 1'b1) pulses.push_back(e);
            if (pulses.size() > 0 && bus.product !== 16'h2A2B) stable = 1'b0;
        end
        bus.start = 1'b0;
        check("b2b_pulses", 32'(pulses.size()), 32'd2);
        if (pulses.size() == 2) begin
            check("b2b_first", 32'(pulses[0]), 32'd9);
            check("b2b_gap", 32'(pulses[1] - pulses[0]), 32'd10);
        end
        check("b2b_stable", 32'(stable), 32'd1);
        cnt_done = 0;
        for (int e = 0; e < 15 && cnt_done == 0; e++) begin
            step();
            if (bus.done === 1'b1) cnt_done++;
        end
        check("b2b_third_done", 32'(cnt_done), 32'd1);
        step();

        // Reset mid-operation.
        bus.multiplicand = 8'h12;
        bus.multiplier   = 8'h34;
        bus.signed_mode  = 1'b0;
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_product", 32'(bus.product), 32'h0000);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        cnt_done = 0;
        for (int e = 0; e < 12; e++) begin
            step();
            if (bus.done !== 1'b0) cnt_done++;
        end
        check("midrst_no_done", 32'(cnt_done), 32'd0);
        check("midrst_product_held", 32'(bus.product), 32'h0000);
        run_op(8'h12, 8'h34, 1'b0, "after_rst", -1);
        check("after_rst_value", 32'(bus.product), 32'h03A8);

        for (int i = 0; i < 16; i++) begin
            rm = 8'($urandom);
            rq = 8'($urandom);
            rs = 1'($urandom);
            run_op(rm, rq, rs, $sformatf("rand%0d", i), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
